quad_phase_monitor: RTL and testbench

- Downstream consumer of the quadrature phase generator.
- Takes the four clk/4 phase signals (0/90/180/270), which are synchronous to clk. Checks that they follow the legal Gray sequence and complement relationship, and reports lock status and errors.
- Produces a phase index, per-phase rising-edge strobes, and one selected phase output.
- The selected phase switches only at the frame boundary, so the output never glitches.

---
 rtl/quad_phase_monitor.sv | 159 +++++++++++++++
 tb/tb_quad_phase_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_phase_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | quad_phase_monitor                                                          |
// | Checks clk/4 quadrature phases for Gray order and complement pairing,       |
// | tracks lock, counts errors, emits edge strobes and a glitch-free selected  |
// | phase. Optional falling-edge strobes: define QPM_FALL_DET_EN.              |
// | Revision: 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+

module quad_phase_monitor #(
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ph_0,
  input  logic             ph_90,
  input  logic             ph_180,
  input  logic             ph_270,
  input  logic [1:0]       sel,
  output logic [1:0]       phase_idx,
  output logic [3:0]       rise,
  output logic [3:0]       fall,
  output logic             sel_ph,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_UNLOCK = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);

  state_t      state_q;
  logic [3:0]  ph_q;
  logic [3:0]  ph_qq;
  logic [1:0]  sel_q;
  logic [1:0]  active_sel_q;
  logic        valid_q;
  logic        prev_valid_q;
  logic [7:0]  good_cnt_q;

  logic [1:0]  w_idx;
  logic [1:0]  w_prev_idx;
  logic        w_seq_ok;
  logic        w_legal;
  logic        w_frame0;
  logic [1:0]  w_sel;
  logic [3:0]  w_rise;
  logic [7:0]  w_good_inc;

  // Gray code {ph_0,ph_90} 00->10->11->01 maps to index {ph_90, ph_0^ph_90}.
  assign w_idx      = {ph_q[1], ph_q[0] ^ ph_q[1]};
  assign w_prev_idx = {ph_qq[1], ph_qq[0] ^ ph_qq[1]};
  assign w_seq_ok   = ~prev_valid_q | (w_idx == (w_prev_idx + 2'd1));
  assign w_legal    = (ph_q[2] == ~ph_q[0]) & (ph_q[3] == ~ph_q[1]) & w_seq_ok;

  // sel travels with its sample so a change landing on index 0 applies at once.
  assign w_frame0   = valid_q & (ph_q[1:0] == 2'b00);
  assign w_sel      = w_frame0 ? sel_q : active_sel_q;
  assign w_rise     = prev_valid_q ? (ph_q & ~ph_qq) : 4'b0000;
  assign w_good_inc = good_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_UNLOCK;
      ph_q         <= 4'b0000;
      ph_qq        <= 4'b0000;
      sel_q        <= 2'd0;
      active_sel_q <= 2'd0;
      valid_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      good_cnt_q   <= 8'd0;
      phase_idx    <= 2'd0;
      rise         <= 4'b0000;
      sel_ph       <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= '0;
    end else begin
      ph_q         <= {ph_270, ph_180, ph_90, ph_0};
      ph_qq        <= ph_q;
      sel_q        <= sel;
      valid_q      <= 1'b1;
      prev_valid_q <= valid_q;
      phase_idx    <= w_idx;
      rise         <= w_rise;
      sel_ph       <= ph_q[w_sel];
      err          <= 1'b0;
      if (w_frame0) begin
        active_sel_q <= sel_q;
      end
      case (state_q)
        S_UNLOCK: begin
          if (prev_valid_q && w_legal) begin
            good_cnt_q <= 8'd1;
            if (LOCK_TGT <= 8'd1) begin
              state_q <= S_LOCKED;
              locked  <= 1'b1;
            end else begin
              state_q <= S_ACQ;
            end
          end
        end
        S_ACQ: begin
          if (w_legal) begin
            good_cnt_q <= w_good_inc;
            if (w_good_inc == LOCK_TGT) begin
              state_q <= S_LOCKED;
              locked  <= 1'b1;
            end
          end else begin
            state_q    <= S_UNLOCK;
            good_cnt_q <= 8'd0;
          end
        end
        S_LOCKED: begin
          if (!w_legal) begin
            err        <= 1'b1;
            state_q    <= S_UNLOCK;
            locked     <= 1'b0;
            good_cnt_q <= 8'd0;
            if (!(&err_cnt)) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
          end
        end
        default: begin
          state_q    <= S_UNLOCK;
          locked     <= 1'b0;
          good_cnt_q <= 8'd0;
        end
      endcase
    end
  end

`ifdef QPM_FALL_DET_EN
  logic [3:0] fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall_q <= 4'b0000;
    end else begin
      fall_q <= prev_valid_q ? (~ph_q & ph_qq) : 4'b0000;
    end
  end

  assign fall = fall_q;
`else
  assign fall = 4'b0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quad_phase_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_quad_phase_monitor                                                       |
// | Scoreboard bench for quad_phase_monitor (ERR_W=8 and ERR_W=2 instances).   |
// | Revision: 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+

module tb_quad_phase_monitor;

  localparam int LC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ph_0 = 1'b0, ph_90 = 1'b0, ph_180 = 1'b0, ph_270 = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [1:0] phase_idx, phase_idx2;
  logic [3:0] rise, rise2, fall, fall2;
  logic       sel_ph, sel_ph2, locked, locked2, err, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  always #5 clk = ~clk;

  quad_phase_monitor #(.LOCK_CNT(LC), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .ph_0(ph_0), .ph_90(ph_90), .ph_180(ph_180), .ph_270(ph_270),
    .sel(sel), .phase_idx(phase_idx), .rise(rise), .fall(fall), .sel_ph(sel_ph),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  quad_phase_monitor #(.LOCK_CNT(LC), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .ph_0(ph_0), .ph_90(ph_90), .ph_180(ph_180), .ph_270(ph_270),
    .sel(sel), .phase_idx(phase_idx2), .rise(rise2), .fall(fall2), .sel_ph(sel_ph2),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2)
  );

  typedef struct {
    int         tag;
    logic [1:0] idx;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       sel_ph;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Spec-level reference state
  int         nsamp, good, errs;
  logic [1:0] prev_idx, act_sel, pidx;
  logic [3:0] prev_vec;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
        mon_e = sbq.pop_front();
        check("sb_tag", 32'(mon_e.tag), 32'(cyc));
        check("phase_idx", 32'(phase_idx), 32'(mon_e.idx));
        check("rise",      32'(rise),      32'(mon_e.rise));
        check("fall",      32'(fall),      32'(mon_e.fall));
        check("sel_ph",    32'(sel_ph),    32'(mon_e.sel_ph));
        check("locked",    32'(locked),    32'(mon_e.locked));
        check("err",       32'(err),       32'(mon_e.err));
        check("err_cnt",   32'(err_cnt),   32'(mon_e.cnt));
        check("err2",      32'(err2),      32'(mon_e.err));
        check("err_cnt2",  32'(err_cnt2),  32'(mon_e.cnt2));
      end
    end
  end

  task automatic model_reset();
    nsamp    = 0;
    good     = 0;
    errs     = 0;
    prev_idx = 2'd0;
    act_sel  = 2'd0;
    prev_vec = 4'b0000;
  endtask

  // Drive one sample at a negedge and push its expected response.
  task automatic drive(input logic [1:0] idx, input bit bad, input logic [1:0] s);
    exp_t       e;
    logic       p0, p90, p180, p270, legal, first;
    logic [3:0] vec;
    p0    = (idx == 2'd1) || (idx == 2'd2);
    p90   = (idx == 2'd2) || (idx == 2'd3);
    p180  = bad ? p0 : ~p0;
    p270  = ~p90;
    vec   = {p270, p180, p90, p0};
    nsamp++;
    first = (nsamp == 1);
    legal = (p180 == ~p0) && (p270 == ~p90) && (first || idx == prev_idx + 2'd1);
    e.err = 1'b0;
    if (!first) begin
      if (legal) begin
        if (good < LC) good++;
      end else begin
        if (good >= LC) begin
          e.err = 1'b1;
          errs++;
        end
        good = 0;
      end
    end
    if (idx == 2'd0) act_sel = s;
    e.tag    = cyc + 2;
    e.idx    = idx;
    e.rise   = first ? 4'b0000 : (vec & ~prev_vec);
`ifdef QPM_FALL_DET_EN
    e.fall   = first ? 4'b0000 : (~vec & prev_vec);
`else
    e.fall   = 4'b0000;
`endif
    e.sel_ph = vec[act_sel];
    e.locked = (good >= LC);
    e.cnt    = 8'(errs);
    e.cnt2   = (errs > 3) ? 2'd3 : 2'(errs);
    sbq.push_back(e);
    ph_0 = p0; ph_90 = p90; ph_180 = p180; ph_270 = p270; sel = s;
    prev_vec = vec;
    prev_idx = idx;
    @(negedge clk);
  endtask

  task automatic run_legal(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) begin
      drive(pidx, 1'b0, s);
      pidx = pidx + 2'd1;
    end
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    sbq.delete();
    #1;
    check("rst_phase_idx", 32'(phase_idx), 32'd0);
    check("rst_rise",      32'(rise),      32'd0);
    check("rst_fall",      32'(fall),      32'd0);
    check("rst_sel_ph",    32'(sel_ph),    32'd0);
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_err_cnt2",  32'(err_cnt2),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    pidx = 2'd0;
    @(negedge clk);
    do_reset();

    // Lock on a clean sequence
    run_legal(14, 2'd0);

    // One cycle with ph_180 == ph_0 while locked, then relock
    drive(pidx, 1'b1, 2'd0);
    pidx = pidx + 2'd1;
    run_legal(10, 2'd0);

    // Skip a code: 00 -> 11
    while (pidx != 2'd1) run_legal(1, 2'd0);
    pidx = 2'd2;
    run_legal(11, 2'd0);

    // sel 0 -> 2 at index 2; takes effect at the next index 0
    while (pidx != 2'd2) run_legal(1, 2'd0);
    run_legal(12, 2'd2);

    // sel change coinciding with an index-0 sample
    while (pidx != 2'd0) run_legal(1, 2'd2);
    run_legal(8, 2'd1);

    // Five errors while locked: ERR_W=2 counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      drive(pidx, 1'b1, 2'd1);
      pidx = pidx + 2'd1;
      run_legal(9, 2'd1);
    end

    // Drop lock, reset mid-acquisition, reacquire
    drive(pidx, 1'b1, 2'd0);
    pidx = pidx + 2'd1;
    run_legal(4, 2'd0);
    do_reset();
    run_legal(14, 2'd0);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
